// File: rtl/vx_barrier_ctrl_pkg.sv
// vx_barrier_ctrl_pkg: shared sizes and request/release record types for the barrier controller
package vx_barrier_ctrl_pkg;
    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int REL_DEPTH    = 2;
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    typedef struct packed {
        logic               valid;
        logic [NB_BITS-1:0] id;
        logic [NW_BITS-1:0] size_m1;
        logic [NW_BITS-1:0] wid;
        logic               wait_en;
    } gpu_barrier_req_t;

    typedef struct packed {
        logic [NB_BITS-1:0]   id;
        logic [NUM_WARPS-1:0] wmask;
    } gpu_barrier_rel_t;

    localparam int GPU_BARRIER_REQ_BITS = $bits(gpu_barrier_req_t);
    localparam int GPU_BARRIER_REL_BITS = $bits(gpu_barrier_rel_t);
endpackage

// File: rtl/vx_barrier_rel_queue.sv
// vx_barrier_rel_queue: small valid/ready FIFO holding completed barrier releases
import vx_barrier_ctrl_pkg::*;

module vx_barrier_rel_queue #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  gpu_barrier_rel_t push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output gpu_barrier_rel_t pop_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    gpu_barrier_rel_t mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push, do_pop;

    assign push_ready = count != CW'(DEPTH);
    assign pop_valid  = count != '0;
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;

    // storage, wrapping pointers and occupancy; a full queue refuses pushes even while popping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: multi-slot warp barrier with arrive-only mode, buffered releases and sticky error
import vx_barrier_ctrl_pkg::*;

module vx_barrier_ctrl #(
    parameter int REL_DEPTH_P = REL_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NB_BITS-1:0]      req_id,
    input  logic [NW_BITS-1:0]      req_size_m1,
    input  logic [NW_BITS-1:0]      req_wid,
    input  logic                    req_wait,
    output logic                    rel_valid,
    input  logic                    rel_ready,
    output logic [NB_BITS-1:0]      rel_id,
    output logic [NUM_WARPS-1:0]    rel_wmask,
    output logic [NUM_WARPS-1:0]    stalled_wmask,
    output logic [NUM_BARRIERS-1:0] bar_active,
    output logic                    err
);
    gpu_barrier_req_t      req;
    gpu_barrier_rel_t      push_rel, pop_rel;
    logic                  q_ready, push_valid, fire, pop;
    logic                  cur_act, dup, done, mismatch;
    logic [NUM_BARRIERS-1:0] active;
    logic [NW_BITS-1:0]    cnt    [NUM_BARRIERS];
    logic [NW_BITS-1:0]    size_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]  wmask  [NUM_BARRIERS];
    logic [NW_BITS-1:0]    cur_cnt, cur_size;
    logic [NUM_WARPS-1:0]  wbit, new_mask;

    assign req        = '{valid: req_valid, id: req_id, size_m1: req_size_m1, wid: req_wid, wait_en: req_wait};
    assign req_ready  = reset && q_ready;
    assign fire       = req.valid && req_ready;
    assign pop        = rel_valid && rel_ready;
    assign cur_act    = active[req.id];
    assign cur_cnt    = cur_act ? cnt[req.id] : '0;
    assign cur_size   = cur_act ? size_q[req.id] : req.size_m1;
    assign wbit       = req.wait_en ? (NUM_WARPS'(1) << req.wid) : '0;
    assign dup        = cur_act && |(wmask[req.id] & wbit);
    assign mismatch   = cur_act && (req.size_m1 != size_q[req.id]);
    assign new_mask   = (cur_act ? wmask[req.id] : '0) | wbit;
    assign done       = fire && !dup && (cur_cnt == cur_size);
    assign push_valid = done && |new_mask;
    assign push_rel   = '{id: req.id, wmask: new_mask};
    assign rel_id     = pop_rel.id;
    assign rel_wmask  = pop_rel.wmask;
    assign bar_active = active;

    // slot bookkeeping: count arrivals, latch size on first one, clear the slot on completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= '0;
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                cnt[i]    <= '0;
                size_q[i] <= '0;
                wmask[i]  <= '0;
            end
        end else if (fire && !dup) begin
            active[req.id] <= !done;
            cnt[req.id]    <= done ? '0 : cur_cnt + NW_BITS'(1);
            wmask[req.id]  <= done ? '0 : new_mask;
            if (!cur_act) size_q[req.id] <= req.size_m1;
        end
    end

    // stall tracking (a new wait beats a same-edge release) and the sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stalled_wmask <= '0;
            err           <= 1'b0;
        end else begin
            stalled_wmask <= (stalled_wmask & ~(pop ? rel_wmask : '0)) | ((fire && !dup) ? wbit : '0);
            if (fire && (dup || mismatch)) err <= 1'b1;
        end
    end

    vx_barrier_rel_queue #(.DEPTH(REL_DEPTH_P)) u_rel_queue (
        .clk       (clk),
        .reset     (reset),
        .push_valid(push_valid),
        .push_ready(q_ready),
        .push_data (push_rel),
        .pop_valid (rel_valid),
        .pop_ready (rel_ready),
        .pop_data  (pop_rel)
    );
endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// tb_vx_barrier_ctrl: directed scenarios plus random traffic against an arrival-counting model
module tb_vx_barrier_ctrl;
    localparam int NW = 4;
    localparam int NB = 4;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0, req_wait = 1'b0, rel_ready = 1'b0;
    logic [1:0]    req_id = '0, req_size_m1 = '0, req_wid = '0;
    logic          req_ready, rel_valid, err;
    logic [1:0]    rel_id;
    logic [NW-1:0] rel_wmask, stalled_wmask;
    logic [NB-1:0] bar_active;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    vx_barrier_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_id       (req_id),
        .req_size_m1  (req_size_m1),
        .req_wid      (req_wid),
        .req_wait     (req_wait),
        .rel_valid    (rel_valid),
        .rel_ready    (rel_ready),
        .rel_id       (rel_id),
        .rel_wmask    (rel_wmask),
        .stalled_wmask(stalled_wmask),
        .bar_active   (bar_active),
        .err          (err)
    );

    typedef struct {int id; int mask;} rel_t;
    rel_t mq[$];
    int   m_arr [NB];
    int   m_size[NB];
    int   m_mask[NB];
    int   m_stall;
    int   m_err;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference: a barrier fires when the number of distinct arrivals reaches size+1
    always @(posedge clk or negedge reset) begin
        int  s, b;
        bit  acc, pp;
        rel_t r;
        if (!reset) begin
            mq.delete();
            foreach (m_arr[i]) begin m_arr[i] = 0; m_size[i] = 0; m_mask[i] = 0; end
            m_stall = 0;
            m_err   = 0;
        end else begin
            acc = req_valid && (mq.size() < D);
            pp  = (mq.size() > 0) && rel_ready;
            if (pp) begin
                m_stall &= ~mq[0].mask;
                void'(mq.pop_front());
            end
            if (acc) begin
                s = int'(req_id);
                b = req_wait ? (1 << req_wid) : 0;
                if ((m_mask[s] & b) != 0) m_err = 1;
                else begin
                    if (m_arr[s] == 0) m_size[s] = int'(req_size_m1);
                    else if (m_size[s] != int'(req_size_m1)) m_err = 1;
                    m_arr[s]++;
                    m_mask[s] |= b;
                    m_stall   |= b;
                    if (m_arr[s] == m_size[s] + 1) begin
                        if (m_mask[s] != 0) begin
                            r.id = s; r.mask = m_mask[s];
                            mq.push_back(r);
                        end
                        m_arr[s]  = 0;
                        m_mask[s] = 0;
                    end
                end
            end
        end
    end

    // every-cycle comparison of all outputs with the model
    always @(negedge clk) begin
        int ba;
        if (reset && cmp_en) begin
            ba = 0;
            for (int i = 0; i < NB; i++) if (m_arr[i] > 0) ba |= (1 << i);
            chk("req_ready", int'(req_ready), int'(mq.size() < D));
            chk("rel_valid", int'(rel_valid), int'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("rel_id", int'(rel_id), mq[0].id);
                chk("rel_wmask", int'(rel_wmask), mq[0].mask);
            end
            chk("stalled_wmask", int'(stalled_wmask), m_stall);
            chk("bar_active", int'(bar_active), ba);
            chk("err", int'(err), m_err);
        end
    end

    task automatic step(bit v, int id, int sz, int w, bit wt, bit rr);
        req_valid   = v;
        req_id      = id[1:0];
        req_size_m1 = sz[1:0];
        req_wid     = w[1:0];
        req_wait    = wt;
        rel_ready   = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = 1'b0;
        rel_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int rs[NB];
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        cmp_en = 1;

        // 1: reset mid-barrier, then slot 1 re-latches a new size
        step(1, 1, 2, 0, 1, 0);
        chk("t1_active_before", int'(bar_active), 2);
        reset = 1'b0;
        #1;
        chk("t1_rst_req_ready", int'(req_ready), 0);
        chk("t1_rst_rel_valid", int'(rel_valid), 0);
        chk("t1_rst_rel_id", int'(rel_id), 0);
        chk("t1_rst_rel_wmask", int'(rel_wmask), 0);
        chk("t1_rst_stalled", int'(stalled_wmask), 0);
        chk("t1_rst_active", int'(bar_active), 0);
        chk("t1_rst_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 1, 0, 3, 1, 0);
        chk("t1_rel_valid", int'(rel_valid), 1);
        chk("t1_rel_id", int'(rel_id), 1);
        chk("t1_rel_wmask", int'(rel_wmask), 8);
        step(0, 0, 0, 0, 0, 1);

        // 2: four waiting warps on slot 2
        for (int w = 0; w < 4; w++) begin
            step(1, 2, 3, w, 1, 0);
            if (w == 2) chk("t2_not_yet", int'(rel_valid), 0);
        end
        chk("t2_rel_valid", int'(rel_valid), 1);
        chk("t2_rel_id", int'(rel_id), 2);
        chk("t2_rel_wmask", int'(rel_wmask), 15);
        chk("t2_stalled", int'(stalled_wmask), 15);
        step(0, 0, 0, 0, 0, 1);
        chk("t2_unstalled", int'(stalled_wmask), 0);

        // 3: single-warp barrier
        step(1, 0, 0, 1, 1, 0);
        chk("t3_rel_wmask", int'(rel_wmask), 2);
        chk("t3_stalled", int'(stalled_wmask), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_held", int'(stalled_wmask), 2);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_popped", int'(stalled_wmask), 0);

        // 4: mixed and all arrive-only
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 1, 0);
        chk("t4_rel_wmask", int'(rel_wmask), 2);
        step(0, 0, 0, 0, 0, 1);
        step(1, 3, 1, 0, 0, 0);
        chk("t4_active", int'(bar_active), 8);
        step(1, 3, 1, 2, 0, 0);
        chk("t4_no_release", int'(rel_valid), 0);
        chk("t4_cleared", int'(bar_active), 0);
        chk("t4_err", int'(err), 0);

        // 5: back-pressure with a full release queue
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1, 0);
        chk("t5_full", int'(req_ready), 0);
        chk("t5_head0", int'(rel_id), 0);
        step(1, 2, 0, 2, 1, 1);
        chk("t5_head1", int'(rel_id), 1);
        chk("t5_ready", int'(req_ready), 1);
        step(1, 2, 0, 2, 1, 1);
        chk("t5_head2", int'(rel_id), 2);
        chk("t5_mask2", int'(rel_wmask), 4);
        step(0, 0, 0, 0, 0, 1);
        chk("t5_drained", int'(rel_valid), 0);

        // 6: duplicate arrival and size mismatch
        step(1, 0, 3, 2, 1, 0);
        step(1, 0, 3, 2, 1, 0);
        chk("t6_err_dup", int'(err), 1);
        chk("t6_active", int'(bar_active), 1);
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 3, 1, 1, 0);
        chk("t6_dup_not_counted", int'(rel_valid), 0);
        step(1, 0, 3, 3, 1, 0);
        chk("t6_rel_wmask", int'(rel_wmask), 15);
        chk("t6_err_sticky", int'(err), 1);
        step(0, 0, 0, 0, 0, 1);

        // random traffic
        do_reset();
        foreach (rs[i]) rs[i] = $urandom_range(0, 3);
        for (int c = 0; c < 3000; c++) begin
            int id, sz;
            if (c % 500 == 499) do_reset();
            id = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) rs[id] = $urandom_range(0, 3);
            sz = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : rs[id];
            step($urandom_range(0, 3) != 0, id, sz, $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) step(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
